// File: rtl/uart_bridge_pkg.sv
// Shared encodings for the UART-to-register bridge: FSM states, frame command
// bytes and response bytes.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_SEND
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_NAK   = 8'h3F;  // '?'

    localparam int TMO_W = 17;

endpackage

// File: rtl/uart_bridge_timeout.sv
// Inter-byte silence counter: counts while enabled, saturates at the limit and
// reports expiry while still enabled.
module uart_bridge_timeout
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-level read/write command parser between a UART and an 8-bit register
// file; every accepted frame yields exactly one response byte.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    state_e     state_q, state_d;
    logic       is_write_q, is_write_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       tx_sent_q, tx_sent_d;

    logic in_frame;
    logic expired;

    assign in_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

    uart_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (received || !in_frame),
        .enable (in_frame),
        .expired(expired)
    );

    // is_transmitting may still be high from an earlier byte, so SEND only
    // leaves once our own request has been seen and the UART has gone busy.
    assign transmit  = (state_q == ST_SEND) && !is_transmitting;
    assign tx_sent_d = (state_q == ST_SEND) && (tx_sent_q || transmit);

    assign reg_we    = (state_q == ST_EXEC) && is_write_q;
    assign reg_re    = (state_q == ST_EXEC) && !is_write_q;
    assign busy      = (state_q != ST_IDLE);
    assign tx_byte   = tx_byte_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tx_byte_d   = tx_byte_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (received) begin
                    if (rx_byte == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = ST_GET_ADDR;
                    end else if (rx_byte == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = ST_GET_ADDR;
                    end else begin
                        tx_byte_d   = RSP_NAK;
                        frame_err_d = 1'b1;
                        state_d     = ST_SEND;
                    end
                end else if (recv_error) begin
                    frame_err_d = 1'b1;
                end
            end

            ST_GET_ADDR: begin
                if (received) begin
                    addr_d  = rx_byte;
                    state_d = is_write_q ? ST_GET_DATA : ST_EXEC;
                end else if (recv_error || expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_GET_DATA: begin
                if (received) begin
                    wdata_d = rx_byte;
                    state_d = ST_EXEC;
                end else if (recv_error || expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_EXEC: begin
                tx_byte_d = is_write_q ? RSP_ACK : reg_rdata;
                overrun_d = overrun_q || received;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                overrun_d = overrun_q || received;
                if (tx_sent_q && is_transmitting) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            tx_byte_q   <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_sent_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_byte_q   <= tx_byte_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            tx_sent_q   <= tx_sent_d;
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed self-checking bench for uart_reg_bridge: write, read, unknown
// command, timeout, overrun, receive-error abort and reset during SEND.
module tb_uart_reg_bridge;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       recv_error = 1'b0;
    logic       is_transmitting = 1'b0;
    logic       transmit;
    logic [7:0] tx_byte;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_reg_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .received       (received),
        .rx_byte        (rx_byte),
        .recv_error     (recv_error),
        .is_transmitting(is_transmitting),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_we         (reg_we),
        .reg_re         (reg_re),
        .reg_rdata      (reg_rdata),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rx  = 0;

    // Event monitor, sampled on the falling edge away from register updates.
    int         we_cnt, re_cnt, tx_cnt, fe_cnt;
    int         we_cyc, re_cyc, tx_cyc;
    logic [7:0] we_addr, we_data, re_addr, tx_cap;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_we)    begin we_cnt++; we_cyc = cyc; we_addr = reg_addr; we_data = reg_wdata; end
        if (reg_re)    begin re_cnt++; re_cyc = cyc; re_addr = reg_addr; end
        if (transmit)  begin tx_cnt++; tx_cyc = cyc; tx_cap = tx_byte; end
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_events();
        we_cnt = 0; re_cnt = 0; tx_cnt = 0; fe_cnt = 0;
        we_cyc = 0; re_cyc = 0; tx_cyc = 0;
        we_addr = 8'h00; we_data = 8'h00; re_addr = 8'h00; tx_cap = 8'h00;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        last_rx  = cyc;
        step(1);
        received = 1'b0;
    endtask

    // Minimal UART transmitter: answers a transmit request with a few busy cycles.
    task automatic serve_tx(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (transmit) seen = 1;
        end
        if (!seen) begin
            check("tx_request_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            is_transmitting = 1'b1;
            step(3);
            is_transmitting = 1'b0;
        end
        step(2);
    endtask

    initial begin
        clr_events();
        step(3);
        rst_n = 1'b1;
        step(1);

        check("rst_transmit",  {31'd0, transmit},  32'd0);
        check("rst_tx_byte",   {24'd0, tx_byte},   32'h00);
        check("rst_reg_addr",  {24'd0, reg_addr},  32'h00);
        check("rst_reg_wdata", {24'd0, reg_wdata}, 32'h00);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_overrun",   {31'd0, overrun},   32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);

        // Write 0x05 <- 0xA5
        clr_events();
        send_byte(8'h57); send_byte(8'h05); send_byte(8'hA5);
        serve_tx(20);
        check("wr_we_count", we_cnt, 1);
        check("wr_we_addr",  {24'd0, we_addr}, 32'h05);
        check("wr_we_data",  {24'd0, we_data}, 32'hA5);
        check("wr_we_cycle", we_cyc, last_rx + 1);
        check("wr_tx_count", tx_cnt, 1);
        check("wr_tx_byte",  {24'd0, tx_cap}, 32'h4B);
        check("wr_tx_cycle", tx_cyc, last_rx + 2);
        check("wr_re_count", re_cnt, 0);
        check("wr_idle",     {31'd0, busy}, 32'd0);

        // Read 0x05 -> 0x3C
        clr_events();
        reg_rdata = 8'h3C;
        send_byte(8'h52); send_byte(8'h05);
        serve_tx(20);
        check("rd_re_count", re_cnt, 1);
        check("rd_re_addr",  {24'd0, re_addr}, 32'h05);
        check("rd_re_cycle", re_cyc, last_rx + 1);
        check("rd_tx_count", tx_cnt, 1);
        check("rd_tx_byte",  {24'd0, tx_cap}, 32'h3C);
        check("rd_tx_cycle", tx_cyc, last_rx + 2);
        check("rd_we_count", we_cnt, 0);

        // Unknown command
        clr_events();
        send_byte(8'h41);
        serve_tx(20);
        check("unk_fe_count", fe_cnt, 1);
        check("unk_tx_count", tx_cnt, 1);
        check("unk_tx_byte",  {24'd0, tx_cap}, 32'h3F);
        check("unk_strobes",  we_cnt + re_cnt, 0);

        // Partial write abandoned by timeout, then a normal read
        clr_events();
        send_byte(8'h57); send_byte(8'h05);
        step(TMO - 5);
        check("tmo_still_busy", {31'd0, busy}, 32'd1);
        check("tmo_no_fe_yet",  fe_cnt, 0);
        step(15);
        check("tmo_idle",     {31'd0, busy}, 32'd0);
        check("tmo_fe_count", fe_cnt, 1);
        check("tmo_tx_count", tx_cnt, 0);
        check("tmo_we_count", we_cnt, 0);
        clr_events();
        reg_rdata = 8'h99;
        send_byte(8'h52); send_byte(8'h05);
        serve_tx(20);
        check("post_tmo_tx_count", tx_cnt, 1);
        check("post_tmo_tx_byte",  {24'd0, tx_cap}, 32'h99);

        // UART busy during SEND, and a byte injected while in SEND
        clr_events();
        is_transmitting = 1'b1;
        reg_rdata = 8'h5A;
        send_byte(8'h52); send_byte(8'h07);
        step(6);
        check("hold_tx_count", tx_cnt, 0);
        check("hold_busy",     {31'd0, busy}, 32'd1);
        check("hold_tx_byte",  {24'd0, tx_byte}, 32'h5A);
        send_byte(8'h11);
        step(1);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        is_transmitting = 1'b0;
        serve_tx(20);
        check("ovr_tx_count", tx_cnt, 1);
        check("ovr_tx_byte",  {24'd0, tx_cap}, 32'h5A);
        check("ovr_idle",     {31'd0, busy}, 32'd0);
        check("ovr_sticky",   {31'd0, overrun}, 32'd1);

        // Receive error in GET_DATA
        clr_events();
        send_byte(8'h57); send_byte(8'h06);
        recv_error = 1'b1;
        step(1);
        recv_error = 1'b0;
        step(4);
        check("rerr_fe_count", fe_cnt, 1);
        check("rerr_idle",     {31'd0, busy}, 32'd0);
        check("rerr_we_count", we_cnt, 0);
        check("rerr_tx_count", tx_cnt, 0);

        // Reset asserted while waiting in SEND
        clr_events();
        is_transmitting = 1'b1;
        reg_rdata = 8'hC3;
        send_byte(8'h57); send_byte(8'h09); send_byte(8'h77);
        step(4);
        check("rsend_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        is_transmitting = 1'b0;
        step(1);
        check("rsend_transmit",  {31'd0, transmit},  32'd0);
        check("rsend_tx_byte",   {24'd0, tx_byte},   32'h00);
        check("rsend_reg_addr",  {24'd0, reg_addr},  32'h00);
        check("rsend_reg_wdata", {24'd0, reg_wdata}, 32'h00);
        check("rsend_busy_low",  {31'd0, busy},      32'd0);
        check("rsend_overrun",   {31'd0, overrun},   32'd0);
        check("rsend_frame_err", {31'd0, frame_err}, 32'd0);
        check("rsend_strobes",   {30'd0, reg_we, reg_re}, 32'd0);
        rst_n = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
